// File: rtl/exhaustive_pattern_capture.sv
// exhaustive_pattern_capture: applies every N_IN-bit pattern to a DUT, holds it for DWELL cycles,
// then streams one {pattern, response} record per pattern over valid/ready. MISR via EXHAUSTIVE_CAPTURE_MISR_EN.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no sweep; pat_out=0, waiting for start
// ST_WAIT | pattern driven, dwell counting up to DWELL-1, then sample
// ST_EMIT | record offered on rec_*, held until rec_valid && rec_ready
// ST_DONE | one-cycle done pulse after the last record was accepted
module exhaustive_pattern_capture #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int DWELL = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  pat_out,
    input  logic [N_OUT-1:0] resp_in,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_pattern,
    output logic [N_OUT-1:0] rec_response,
    output logic             busy,
    output logic             done
`ifdef EXHAUSTIVE_CAPTURE_MISR_EN
    ,
    output logic [15:0]      sig
`endif
);

    localparam int PW  = N_IN + 1;
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0]  LAST_PAT   = PW'((1 << N_IN) - 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    pat_q;
    logic [DCW-1:0]   dwell_q;
    logic [N_IN-1:0]  pat_out_q;
    logic             rec_valid_q;
    logic [N_IN-1:0]  rec_pattern_q;
    logic [N_OUT-1:0] rec_response_q;
    logic             busy_q;
    logic             done_q;

    logic [PW-1:0]    pat_nxt_d;
    logic             last_pat;
    logic             dwell_hit;
    logic             handshake;

    // One extra counter bit keeps the last-pattern compare free of wrap-around.
    assign pat_nxt_d = pat_q + 1'b1;
    assign last_pat  = (pat_q == LAST_PAT);
    assign dwell_hit = (dwell_q == DWELL_LAST);
    assign handshake = rec_valid_q & rec_ready;

`ifdef EXHAUSTIVE_CAPTURE_MISR_EN
    logic [15:0] sig_q;
    logic [15:0] misr_in_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000);
    endfunction

    assign misr_in_d = 16'({rec_pattern_q, rec_response_q});
    assign sig       = sig_q;
`endif

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            pat_q          <= '0;
            dwell_q        <= '0;
            pat_out_q      <= '0;
            rec_valid_q    <= 1'b0;
            rec_pattern_q  <= '0;
            rec_response_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef EXHAUSTIVE_CAPTURE_MISR_EN
            sig_q          <= 16'hFFFF;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q   <= ST_WAIT;
                        pat_q     <= '0;
                        dwell_q   <= '0;
                        pat_out_q <= '0;
                        busy_q    <= 1'b1;
`ifdef EXHAUSTIVE_CAPTURE_MISR_EN
                        sig_q     <= 16'hFFFF;
`endif
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        pat_out_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                        if (dwell_hit) begin
                            rec_pattern_q  <= pat_q[N_IN-1:0];
                            rec_response_q <= resp_in;
                            rec_valid_q    <= 1'b1;
                            state_q        <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    // abort drops the pending record even if the sink accepts it this cycle
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        rec_valid_q <= 1'b0;
                        pat_out_q   <= '0;
                        busy_q      <= 1'b0;
                    end else if (handshake) begin
                        rec_valid_q <= 1'b0;
`ifdef EXHAUSTIVE_CAPTURE_MISR_EN
                        sig_q       <= lfsr_step(sig_q) ^ misr_in_d;
`endif
                        if (last_pat) begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            pat_out_q <= '0;
                        end else begin
                            state_q   <= ST_WAIT;
                            pat_q     <= pat_nxt_d;
                            pat_out_q <= pat_nxt_d[N_IN-1:0];
                            dwell_q   <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pat_out      = pat_out_q;
    assign rec_valid    = rec_valid_q;
    assign rec_pattern  = rec_pattern_q;
    assign rec_response = rec_response_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
